// File: rtl/ndp_drain_pkg.sv
// ndp_drain_pkg: drain FSM state encoding and derived-size helpers for ndp_result_drain
package ndp_drain_pkg;

  typedef enum logic {IDLE, DRAIN} state_t;

  function automatic int row_elems(input int arr_width, input int sys_width);
    return arr_width * sys_width;
  endfunction

  function automatic int num_rows(input int arr_height, input int sys_height);
    return arr_height * sys_height;
  endfunction

  function automatic int beats_per_row(input int elems_per_row, input int beat_elems);
    return elems_per_row / beat_elems;
  endfunction

  // Index widths never drop below 1 bit so degenerate sizes still get a port
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/ndp_beat_select.sv
// ndp_beat_select: picks one output beat out of the snapshot by row/beat index; optional ReLU under NDP_DRAIN_RELU_EN
module ndp_beat_select
  import ndp_drain_pkg::*;
#(
  parameter int WIDTH         = 16,
  parameter int NUM_BEATS     = 64,
  parameter int BEAT_ELEMS    = 16,
  parameter int BEATS_PER_ROW = 16,
  parameter int RW            = 2,
  parameter int BW            = 4
) (
  input  logic [NUM_BEATS*BEAT_ELEMS*WIDTH-1:0] snap,
  input  logic [RW-1:0]                         row,
  input  logic [BW-1:0]                         beat,
  output logic [BEAT_ELEMS*WIDTH-1:0]           data
);

  localparam int BB = BEAT_ELEMS * WIDTH;
  localparam int IW = clog2_min1(NUM_BEATS);

  logic [IW-1:0] idx;
  logic [BB-1:0] raw;

  // Rows are whole multiples of a beat, so the snapshot is just a linear array of beats
  assign idx = IW'(32'(row) * BEATS_PER_ROW + 32'(beat));
  assign raw = snap[idx*BB +: BB];

`ifdef NDP_DRAIN_RELU_EN
  // Clamp any element with its sign bit set; identical for float and integer results
  for (genvar e = 0; e < BEAT_ELEMS; e++) begin : g_relu
    assign data[e*WIDTH +: WIDTH] = raw[e*WIDTH+WIDTH-1] ? '0 : raw[e*WIDTH +: WIDTH];
  end
`else
  assign data = raw;
`endif

endmodule

// File: rtl/ndp_result_drain.sv
// ndp_result_drain: snapshots the NDP result bus on a done edge and streams it out row by row in beats (macro NDP_DRAIN_RELU_EN enables output ReLU)
module ndp_result_drain
  import ndp_drain_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int IS_FLOAT   = 1,
  parameter int ARR_WIDTH  = 4,
  parameter int ARR_HEIGHT = 4,
  parameter int SYS_WIDTH  = 64,
  parameter int SYS_HEIGHT = 1,
  parameter int BEAT_ELEMS = 16
) (
  input  logic                                                   clk,
  input  logic                                                   reset,
  input  logic                                                   calc_done_flag,
  input  logic [ARR_WIDTH*SYS_WIDTH*ARR_HEIGHT*SYS_HEIGHT*WIDTH-1:0] in_c,
  output logic                                                   out_valid,
  input  logic                                                   out_ready,
  output logic [BEAT_ELEMS*WIDTH-1:0]                            out_data,
  output logic [clog2_min1(num_rows(ARR_HEIGHT, SYS_HEIGHT))-1:0] out_row,
  output logic [clog2_min1(beats_per_row(row_elems(ARR_WIDTH, SYS_WIDTH), BEAT_ELEMS))-1:0] out_beat,
  output logic                                                   out_last,
  output logic                                                   busy,
  output logic                                                   overrun
);

  localparam int ROW_ELEMS     = row_elems(ARR_WIDTH, SYS_WIDTH);
  localparam int NUM_ROWS      = num_rows(ARR_HEIGHT, SYS_HEIGHT);
  localparam int BEATS_PER_ROW = beats_per_row(ROW_ELEMS, BEAT_ELEMS);
  localparam int NUM_BEATS     = NUM_ROWS * BEATS_PER_ROW;
  localparam int RW            = clog2_min1(NUM_ROWS);
  localparam int BW            = clog2_min1(BEATS_PER_ROW);
  localparam int SNAP_BITS     = ROW_ELEMS * NUM_ROWS * WIDTH;

  if (ROW_ELEMS % BEAT_ELEMS != 0) begin : g_bad_beat
    $error("ndp_result_drain: ARR_WIDTH*SYS_WIDTH must be a multiple of BEAT_ELEMS");
  end
  if (IS_FLOAT != 0 && IS_FLOAT != 1) begin : g_bad_float
    $error("ndp_result_drain: IS_FLOAT must be 0 or 1");
  end

  state_t               state, state_n;
  logic [RW-1:0]        row;
  logic [BW-1:0]        beat;
  logic [SNAP_BITS-1:0] snap;
  logic                 done_q;
  logic                 done_edge;
  logic                 capture;
  logic                 xfer;
  logic                 row_last;
  logic                 beat_last;

  // done_q resets high so a flag already asserted at reset release is not an edge
  assign done_edge = calc_done_flag & ~done_q;

  // Next state, handshake and position decode
  always_comb begin
    out_valid = (state == DRAIN);
    busy      = out_valid;
    xfer      = out_valid & out_ready;
    row_last  = (row == RW'(NUM_ROWS - 1));
    beat_last = (beat == BW'(BEATS_PER_ROW - 1));
    out_last  = out_valid & row_last & beat_last;
    capture   = (state == IDLE) & done_edge;
    state_n   = capture ? DRAIN : (xfer & out_last) ? IDLE : state;
  end

  // State register, snapshot, beat/row counters, edge history and sticky overrun
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      row     <= '0;
      beat    <= '0;
      snap    <= '0;
      done_q  <= 1'b1;
      overrun <= 1'b0;
    end else begin
      state  <= state_n;
      done_q <= calc_done_flag;
      if (capture) begin
        snap <= in_c;
        row  <= '0;
        beat <= '0;
      end else if (xfer) begin
        beat <= beat_last ? '0 : beat + BW'(1);
        if (beat_last) row <= row_last ? '0 : row + RW'(1);
      end
      if (done_edge && state == DRAIN) overrun <= 1'b1;
    end
  end

  assign out_row  = row;
  assign out_beat = beat;

  ndp_beat_select #(
    .WIDTH        (WIDTH),
    .NUM_BEATS    (NUM_BEATS),
    .BEAT_ELEMS   (BEAT_ELEMS),
    .BEATS_PER_ROW(BEATS_PER_ROW),
    .RW           (RW),
    .BW           (BW)
  ) u_sel (
    .snap(snap),
    .row (row),
    .beat(beat),
    .data(out_data)
  );

endmodule

// File: doc/ndp_result_drain.md
Name: ndp_result_drain

Overview:
Downstream stage of the NDP systolic unit. Snapshots the full flat result bus when the unit signals calculation done, then streams it out row by row in fixed-width beats over a valid/ready handshake toward the writeback/memory interface. Decouples the array from memory backpressure, so the array can start its next feed while the previous result drains.

Parameters:
WIDTH, 16, bits per result element
IS_FLOAT, 1, 1 = results are float (sign at MSB), 0 = two's-complement integer
ARR_WIDTH, 4, PE columns per systolic array
ARR_HEIGHT, 4, PE rows per systolic array
SYS_WIDTH, 64, systolic arrays horizontally
SYS_HEIGHT, 1, systolic arrays vertically
BEAT_ELEMS, 16, elements per output beat; ARR_WIDTH*SYS_WIDTH must divide by it exactly, otherwise elaboration fails

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset (0 = in reset)
calc_done_flag  input  1  from NDP unit: result bus valid while high
in_c  input  ARR_WIDTH*SYS_WIDTH*ARR_HEIGHT*SYS_HEIGHT*WIDTH  flat result bus, row-major, element (r,c) at bit offset (r*ROW_ELEMS+c)*WIDTH
out_valid  output  1  beat valid
out_ready  input  1  consumer accepts beat
out_data  output  BEAT_ELEMS*WIDTH  beat payload; element e at [e*WIDTH +: WIDTH]
out_row  output  clog2(NUM_ROWS) (min 1)  row index of the current beat
out_beat  output  clog2(BEATS_PER_ROW) (min 1)  beat index within the row
out_last  output  1  high on the final beat of the snapshot
busy  output  1  high from capture until the final beat is accepted
overrun  output  1  sticky: a new done edge arrived while busy

Behaviour:
- Derived constants: ROW_ELEMS = ARR_WIDTH*SYS_WIDTH, NUM_ROWS = ARR_HEIGHT*SYS_HEIGHT, BEATS_PER_ROW = ROW_ELEMS/BEAT_ELEMS.
- While reset is low, all outputs are 0, state is IDLE, counters are 0, and the snapshot register is 0. Reset asserted mid-drain aborts immediately; any partial transfer is discarded.
- A done edge is detected when calc_done_flag is high in the current cycle and was low in the previous cycle. The edge register resets to 1, so a flag that is already high when reset is released does not start a drain.
- IDLE: on a done edge in cycle N, latch in_c into the snapshot, clear row and beat counters, and go to DRAIN. out_valid and busy become high in cycle N+1.
- DRAIN: out_valid is held at 1.
  - out_data, out_row and out_beat must stay stable while out_valid=1 and out_ready=0.
  - A beat transfers on out_valid && out_ready at a rising edge.
  - On each transfer, out_beat increments; when it wraps from BEATS_PER_ROW-1 to 0, out_row increments.
  - out_data = snapshot elements (out_row*ROW_ELEMS + out_beat*BEAT_ELEMS + e), for e = 0..BEAT_ELEMS-1.
  - out_last = (out_row == NUM_ROWS-1) && (out_beat == BEATS_PER_ROW-1).
  - A transfer with out_last high returns to IDLE; out_valid and busy fall in the next cycle.
- Throughput is one beat per cycle when out_ready stays high. A full drain takes NUM_ROWS*BEATS_PER_ROW cycles; with the defaults this is 64.
- A done edge during DRAIN, including the same cycle as the last transfer, is not captured and sets overrun. overrun clears only on reset.
- calc_done_flag staying high after capture has no effect; a new drain requires the flag to go low and then high again.
- in_c is sampled only in the capture cycle, so changes to in_c afterwards do not affect the drain.
- Degenerate sizes: when NUM_ROWS=1 or BEATS_PER_ROW=1, the corresponding index output is 1 bit and tied to 0.

Optional Feature:
NDP_DRAIN_RELU_EN:
- When defined, each outgoing element whose MSB is 1 is replaced by 0 on out_data. This covers negative floats, -0.0 and negative integers, and behaves the same for both IS_FLOAT values. The stage is combinational on the mux output and adds no latency.
- When undefined, out_data carries the snapshot elements unmodified.
- The snapshot always holds raw values either way.

Decomposition:
- Package ndp_drain_pkg: state encoding (IDLE, DRAIN) and the derived-size helpers ROW_ELEMS, NUM_ROWS and BEATS_PER_ROW, plus a clog2 helper with a minimum of 1.
- Sub-module ndp_beat_select: combinational mux that takes the snapshot plus row/beat indices and returns the beat. The optional ReLU lives here under the macro.
- FSM, counters, edge detection and the snapshot register live in the top module.

Test Plan:
1. Defaults, element (r,c) = r*256+c, rising edge with out_ready=1 -> out_valid rises in cycle N+1; 64 consecutive beats; beat (2,5) element 0 = 0x0250; out_last only on (3,15); busy falls after the last beat.
2. Backpressure: out_ready toggled randomly -> no beat is lost or duplicated; out_data/out_row/out_beat are stable on every stalled cycle; the scoreboard matches all 64 beats in order.
3. Second rising edge at beat 10 of a drain -> drain continues unaffected; overrun=1 and stays 1; no second drain starts. Flag low then high after IDLE -> a new drain starts normally.
4. Reset asserted asynchronously at beat 20 -> all outputs go to 0 without waiting for a clock edge; after release with calc_done_flag held high, no drain starts until a fresh edge.
5. in_c changed every cycle after capture -> drained data equals the value sampled in the capture cycle.
6. With NDP_DRAIN_RELU_EN, elements 0x8000, 0xBC00 and 0x3C00 -> output 0x0000, 0x0000, 0x3C00. Without the macro -> values pass through unchanged.
